// File: rtl/axi_interconnect_crossbar_pkg.sv
// Shared crossbar constants, index-width helper and beat field offsets.
// Used by the response router and its tracking FIFO.
package axi_interconnect_crossbar_pkg;

   localparam int DEF_DEPTH  = 4;
   localparam int DEF_DATA_W = 32;

   localparam int BEAT_RESP_LSB = 0;
   localparam int BEAT_RESP_W   = 2;
   localparam int BEAT_ID_LSB   = 2;
   localparam int BEAT_ID_W     = 4;
   localparam int BEAT_DATA_LSB = 6;

   // Bits needed to hold the value n (never below 1).
   function automatic int LOG2(input int n);
      int r;
      int v;
      r = 1;
      v = n;
      while (v > 1) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_resp_fifo.sv
// In-order tracking FIFO holding granted master indices.
// Caller gates push with !full and pop with !empty.
module axi_interconnect_crossbar_resp_fifo
   import axi_interconnect_crossbar_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [WIDTH-1:0]   push_data,
   input  logic               pop,
   output logic [WIDTH-1:0]   head,
   output logic               full,
   output logic               empty,
   output logic [LOG2(DEPTH):0] count
);

   localparam int PTR_W = LOG2(DEPTH - 1);
   localparam int CNT_W = LOG2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Storage and pointers; pointers wrap on power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: unchanged on simultaneous push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + 1'b1;
      end else if (pop && !push) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/axi_interconnect_crossbar_resp_route.sv
// Steers slave response beats to the master at the tracking FIFO head.
// Define AXI_XBAR_RESP_REG_EN to insert a two-entry skid register.
module axi_interconnect_crossbar_resp_route
   import axi_interconnect_crossbar_pkg::*;
#(
   parameter int NUM    = 2,
   parameter int WIDTH  = LOG2(NUM - 1),
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                gnt_vld,
   input  logic [WIDTH-1:0]    gnt_user,
   output logic                gnt_rdy,
   input  logic                s_resp_valid,
   input  logic [DATA_W-1:0]   s_resp_data,
   input  logic                s_resp_last,
   output logic                s_resp_ready,
   output logic [NUM-1:0]      m_resp_valid,
   output logic [DATA_W-1:0]   m_resp_data,
   output logic                m_resp_last,
   input  logic [NUM-1:0]      m_resp_ready,
   output logic [LOG2(DEPTH):0] outstanding
);

   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [WIDTH-1:0] head;

   assign gnt_rdy = !full;
   assign push    = gnt_vld && gnt_rdy;

   axi_interconnect_crossbar_resp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (gnt_user),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (outstanding)
   );

`ifndef AXI_XBAR_RESP_REG_EN

   logic head_rdy;

   // Ready of the head master; out-of-range index sinks beats.
   always_comb begin
      head_rdy = 1'b1;
      for (int i = 0; i < NUM; i++) begin
         if (int'(head) == i) begin
            head_rdy = m_resp_ready[i];
         end
      end
   end

   // Combinational route of valid and ready through the head.
   always_comb begin
      m_resp_valid = '0;
      s_resp_ready = 1'b0;
      if (!empty) begin
         s_resp_ready = head_rdy;
         for (int i = 0; i < NUM; i++) begin
            if (int'(head) == i) begin
               m_resp_valid[i] = s_resp_valid;
            end
         end
      end
   end

   assign m_resp_data = s_resp_data;
   assign m_resp_last = s_resp_last && !empty;
   assign pop = s_resp_valid && s_resp_ready
             && s_resp_last;

`else

   typedef struct packed {
      logic [WIDTH-1:0]  idx;
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t out_q;
   beat_t skid_q;
   beat_t in_beat;
   logic  out_vld;
   logic  skid_vld;
   logic  out_rdy;
   logic  in_hs;

   assign in_beat = '{idx:  head,
                      last: s_resp_last,
                      data: s_resp_data};

   // Ready depends only on flops: skid slot free and an entry waiting.
   assign s_resp_ready = !skid_vld && !empty;
   assign in_hs = s_resp_valid && s_resp_ready;
   assign pop   = in_hs && s_resp_last;

   // Ready of the master captured with the output beat.
   always_comb begin
      out_rdy = 1'b1;
      for (int i = 0; i < NUM; i++) begin
         if (int'(out_q.idx) == i) begin
            out_rdy = m_resp_ready[i];
         end
      end
   end

   // One-hot valid toward the captured master.
   always_comb begin
      m_resp_valid = '0;
      for (int i = 0; i < NUM; i++) begin
         if (int'(out_q.idx) == i) begin
            m_resp_valid[i] = out_vld;
         end
      end
   end

   assign m_resp_data = out_q.data;
   assign m_resp_last = out_q.last;

   // Output stage with skid slot for full throughput under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!out_vld || out_rdy) begin
         if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else begin
            out_vld <= in_hs;
            if (in_hs) begin
               out_q <= in_beat;
            end
         end
      end else if (in_hs) begin
         skid_q   <= in_beat;
         skid_vld <= 1'b1;
      end
   end

`endif

endmodule

// File: tb/tb_axi_interconnect_crossbar_resp_route.sv
// Directed vector bench for the response router, NUM=4 DEPTH=4.
// Covers both the combinational and AXI_XBAR_RESP_REG_EN builds.
module tb_axi_interconnect_crossbar_resp_route;

   localparam int NUM    = 4;
   localparam int WIDTH  = 2;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              gnt_vld;
   logic [WIDTH-1:0]  gnt_user;
   logic              gnt_rdy;
   logic              s_resp_valid;
   logic [DATA_W-1:0] s_resp_data;
   logic              s_resp_last;
   logic              s_resp_ready;
   logic [NUM-1:0]    m_resp_valid;
   logic [DATA_W-1:0] m_resp_data;
   logic              m_resp_last;
   logic [NUM-1:0]    m_resp_ready;
   logic [3:0]        outstanding;

   int checks;
   int errors;

   axi_interconnect_crossbar_resp_route #(
      .NUM    (NUM),
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .gnt_vld      (gnt_vld),
      .gnt_user     (gnt_user),
      .gnt_rdy      (gnt_rdy),
      .s_resp_valid (s_resp_valid),
      .s_resp_data  (s_resp_data),
      .s_resp_last  (s_resp_last),
      .s_resp_ready (s_resp_ready),
      .m_resp_valid (m_resp_valid),
      .m_resp_data  (m_resp_data),
      .m_resp_last  (m_resp_last),
      .m_resp_ready (m_resp_ready),
      .outstanding  (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        gv;
      logic [1:0]  gu;
      logic        sv;
      logic [31:0] sd;
      logic        sl;
      logic [3:0]  mr;
      logic        grdy;
      logic        srdy;
      logic [3:0]  mv;
      logic [3:0]  occ;
   } vec_t;

   vec_t tv[$];

   function automatic void add(
      input logic gv, input logic [1:0] gu,
      input logic sv, input logic [31:0] sd,
      input logic sl, input logic [3:0] mr,
      input logic grdy, input logic srdy,
      input logic [3:0] mv, input logic [3:0] occ);
      vec_t v;
      v.gv = gv; v.gu = gu; v.sv = sv;
      v.sd = sd; v.sl = sl; v.mr = mr;
      v.grdy = grdy; v.srdy = srdy;
      v.mv = mv; v.occ = occ;
      tv.push_back(v);
   endfunction

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h",
                  name, act, exp);
      end
   endtask

   task automatic drive(input logic gv,
                        input logic [1:0] gu,
                        input logic sv,
                        input logic [31:0] sd,
                        input logic sl,
                        input logic [3:0] mr);
      gnt_vld      = gv;
      gnt_user     = gu;
      s_resp_valid = sv;
      s_resp_data  = sd;
      s_resp_last  = sl;
      m_resp_ready = mr;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".occ"},  64'(outstanding), 64'd0);
      chk({tag, ".grdy"}, 64'(gnt_rdy), 64'd1);
      chk({tag, ".srdy"}, 64'(s_resp_ready), 64'd0);
      chk({tag, ".mv"},   64'(m_resp_valid), 64'd0);
      chk({tag, ".last"}, 64'(m_resp_last), 64'd0);
   endtask

   initial begin
      logic [1:0] pv [8];
      logic [1:0] hd [10];
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(0, 0, 0, 0, 0, 4'hF);
      #12;
      check_reset("rst");
`ifdef AXI_XBAR_RESP_REG_EN
      chk("rst.data", 64'(m_resp_data), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

`ifndef AXI_XBAR_RESP_REG_EN
      // two bursts to masters 2 then 0
      add(1,2, 0,32'h0,   0,4'hF, 1,0,4'b0000,0);
      add(1,0, 1,32'hA1,  0,4'hF, 1,1,4'b0100,1);
      add(0,0, 1,32'hA2,  0,4'hF, 1,1,4'b0100,2);
      add(0,0, 1,32'hA3,  1,4'hF, 1,1,4'b0100,2);
      add(0,0, 1,32'hB1,  1,4'hF, 1,1,4'b0001,1);
      add(0,0, 0,32'h0,   0,4'hF, 1,0,4'b0000,0);
      // empty FIFO holds beat until grant
      add(0,0, 1,32'hC1,  1,4'hF, 1,0,4'b0000,0);
      add(1,1, 1,32'hC1,  1,4'hF, 1,0,4'b0000,0);
      // master 1 stalled, then released
      add(0,0, 1,32'hC1,  0,4'hD, 1,0,4'b0010,1);
      add(0,0, 1,32'hC1,  0,4'hD, 1,0,4'b0010,1);
      add(0,0, 1,32'hC2,  1,4'hF, 1,1,4'b0010,1);
      add(0,0, 0,32'h0,   0,4'hF, 1,0,4'b0000,0);
      // prefill two, then push+pop across wrap
      add(1,3, 0,32'h0,   0,4'hF, 1,0,4'b0000,0);
      add(1,1, 0,32'h0,   0,4'hF, 1,1,4'b0000,1);
      pv = '{2'd0, 2'd2, 2'd3, 2'd1,
             2'd2, 2'd0, 2'd1, 2'd3};
      hd[0] = 2'd3;
      hd[1] = 2'd1;
      for (int k = 0; k < 8; k++) hd[k+2] = pv[k];
      for (int k = 0; k < 8; k++) begin
         add(1, pv[k], 1, 32'(k + 16), 1, 4'hF,
             1, 1, 4'(1 << hd[k]), 2);
      end
      add(0,0, 1,32'hD0,  1,4'hF, 1,1,
          4'(1 << hd[8]), 2);
      add(0,0, 1,32'hD1,  1,4'hF, 1,1,
          4'(1 << hd[9]), 1);
      // fill to DEPTH, full blocks a concurrent pop
      add(1,0, 0,32'h0,   0,4'hF, 1,0,4'b0000,0);
      add(1,1, 0,32'h0,   0,4'hF, 1,1,4'b0000,1);
      add(1,2, 0,32'h0,   0,4'hF, 1,1,4'b0000,2);
      add(1,3, 0,32'h0,   0,4'hF, 1,1,4'b0000,3);
      add(1,2, 0,32'h0,   0,4'hF, 0,1,4'b0000,4);
      add(1,2, 1,32'hE0,  1,4'hF, 0,1,4'b0001,4);
      add(1,2, 0,32'h0,   0,4'hF, 1,1,4'b0000,3);
      add(0,0, 0,32'h0,   0,4'hF, 0,1,4'b0000,4);
      add(0,0, 1,32'hE1,  0,4'hF, 0,1,4'b0010,4);

      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i].gv, tv[i].gu, tv[i].sv,
               tv[i].sd, tv[i].sl, tv[i].mr);
         #1;
         chk($sformatf("v%0d.grdy", i),
             64'(gnt_rdy), 64'(tv[i].grdy));
         chk($sformatf("v%0d.srdy", i),
             64'(s_resp_ready), 64'(tv[i].srdy));
         chk($sformatf("v%0d.mv", i),
             64'(m_resp_valid), 64'(tv[i].mv));
         chk($sformatf("v%0d.occ", i),
             64'(outstanding), 64'(tv[i].occ));
         if (tv[i].mv != 4'b0000) begin
            chk($sformatf("v%0d.data", i),
                64'(m_resp_data), 64'(tv[i].sd));
         end
      end

      // reset mid-burst, beat keeps waiting afterwards
      @(negedge clk);
      drive(0, 0, 1, 32'hF0, 1, 4'hF);
      #1;
      chk("mr.pre.mv", 64'(m_resp_valid), 64'h2);
      rst_n = 1'b0;
      #1;
      check_reset("mr.async");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mr.wait.srdy", 64'(s_resp_ready), 64'd0);
      chk("mr.wait.mv", 64'(m_resp_valid), 64'd0);
      @(negedge clk);
      drive(1, 3, 1, 32'hF1, 1, 4'hF);
      #1;
      chk("mr.gnt.srdy", 64'(s_resp_ready), 64'd0);
      chk("mr.gnt.mv", 64'(m_resp_valid), 64'd0);
      @(negedge clk);
      drive(0, 0, 1, 32'hF1, 1, 4'hF);
      #1;
      chk("mr.route.mv", 64'(m_resp_valid), 64'h8);
      chk("mr.route.srdy", 64'(s_resp_ready), 64'd1);
      chk("mr.route.data", 64'(m_resp_data), 64'hF1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 4'hF);
      #1;
      chk("mr.end.occ", 64'(outstanding), 64'd0);
`else
      begin
         logic        gv_s [7];
         logic [1:0]  gu_s [7];
         logic        sv_s [7];
         logic [31:0] sd_s [7];
         logic        sl_s [7];
         logic        rd_s [7];
         logic [3:0]  mv_s [7];
         logic [31:0] md_s [7];
         logic [3:0]  oc_s [7];
         gv_s = '{1,1,0,0,0,0,0};
         gu_s = '{2,0,0,0,0,0,0};
         sv_s = '{0,1,1,1,1,0,0};
         sd_s = '{0,32'hA1,32'hA2,32'hA3,
                  32'hB1,0,0};
         sl_s = '{0,0,0,1,1,0,0};
         rd_s = '{0,1,1,1,1,0,0};
         mv_s = '{4'h0,4'h0,4'h4,4'h4,
                  4'h4,4'h1,4'h0};
         md_s = '{0,0,32'hA1,32'hA2,
                  32'hA3,32'hB1,0};
         oc_s = '{0,1,2,2,1,0,0};
         for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(gv_s[i], gu_s[i], sv_s[i],
                  sd_s[i], sl_s[i], 4'hF);
            #1;
            chk($sformatf("r%0d.srdy", i),
                64'(s_resp_ready), 64'(rd_s[i]));
            chk($sformatf("r%0d.mv", i),
                64'(m_resp_valid), 64'(mv_s[i]));
            chk($sformatf("r%0d.occ", i),
                64'(outstanding), 64'(oc_s[i]));
            if (mv_s[i] != 4'h0) begin
               chk($sformatf("r%0d.data", i),
                   64'(m_resp_data), 64'(md_s[i]));
            end
         end
      end
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
